cdb_arbiter: RTL and testbench

Round-robin arbiter sharing the single Common Data Bus (CDB) among the execution units (load buffer, store buffer, branch unit, ALU, MULT, DIV, FPU, dummy coprocessor). The block sits between the unit result outputs and the ROB/reservation-station broadcast, and grants at most one result per cycle. The winning result goes into a one-entry output register, so the CDB is driven from a flop. A flush from the commit stage discards any buffered result.

---
 rtl/cdb_arbiter.sv | 80 ++++++++
 tb/tb_cdb_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Shares the single CDB among EU_N execution units; round-robin or fixed-priority grant.
// Latency: one cycle from unit accept to registered cdb_valid_o/cdb_payload_o/cdb_src_o.
// Backpressure: a stalled CDB register or a flush drops every eu_ready_o bit in the same cycle.
module cdb_arbiter #(
    parameter int EU_N      = 8,
    parameter int PAYLOAD_W = 72,
    parameter bit RR_EN     = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [EU_N-1:0]             eu_valid_i,
    output logic [EU_N-1:0]             eu_ready_o,
    input  logic [EU_N*PAYLOAD_W-1:0]   eu_payload_i,
    output logic                        cdb_valid_o,
    input  logic                        cdb_ready_i,
    output logic [PAYLOAD_W-1:0]        cdb_payload_o,
    output logic [$clog2(EU_N)-1:0]     cdb_src_o
);

    localparam int PTR_W = $clog2(EU_N);

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic [PTR_W-1:0]     ptr_nxt;
    logic                 gnt_any;
    logic                 can_load;
    logic                 xfer;
    logic [PAYLOAD_W-1:0] gnt_payload;

    // Scan from the pointer with an explicit wrap so non-power-of-two EU_N works.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < EU_N; k++) begin
            int idx;
            idx = (RR_EN ? int'(ptr) : 0) + k;
            if (idx >= EU_N) begin
                idx = idx - EU_N;
            end
            if (!gnt_any && eu_valid_i[idx[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PTR_W-1:0];
            end
        end
    end

    assign can_load    = !flush_i && (!cdb_valid_o || cdb_ready_i);
    assign xfer        = can_load && gnt_any;
    assign ptr_nxt     = (gnt_idx == PTR_W'(EU_N - 1)) ? '0 : gnt_idx + 1'b1;
    assign gnt_payload = eu_payload_i[int'(gnt_idx)*PAYLOAD_W +: PAYLOAD_W];

    always_comb begin
        eu_ready_o = '0;
        if (xfer) begin
            eu_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cdb_valid_o   <= 1'b0;
            cdb_payload_o <= '0;
            cdb_src_o     <= '0;
            ptr           <= '0;
        end else if (flush_i) begin
            cdb_valid_o <= 1'b0;
        end else if (xfer) begin
            cdb_valid_o   <= 1'b1;
            cdb_payload_o <= gnt_payload;
            cdb_src_o     <= gnt_idx;
            if (RR_EN) begin
                ptr <= ptr_nxt;
            end
        end else if (cdb_valid_o && cdb_ready_i) begin
            cdb_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a round-robin and a fixed-priority instance share one stimulus,
// checked every cycle against a queue-free reference model plus directed literal expectations.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        cdb_ready = 1'b0;
    logic [7:0]  eu_valid = 8'h00;
    logic [71:0] pay [8];
    logic [575:0] eu_payload;

    logic [7:0]  rdy [2];
    logic        cv  [2];
    logic [71:0] cp  [2];
    logic [2:0]  cs  [2];

    int checks = 0;
    int errors = 0;

    // model state, index 0 = round-robin instance, 1 = fixed-priority instance
    logic        mv   [2];
    logic [71:0] mp   [2];
    int          ms   [2];
    int          mptr [2];

    always #5 clk = ~clk;

    always_comb begin
        eu_payload = '0;
        for (int i = 0; i < 8; i++) eu_payload[i*72 +: 72] = pay[i];
    end

    cdb_arbiter #(.EU_N(8), .PAYLOAD_W(72), .RR_EN(1'b1)) u_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .eu_valid_i(eu_valid), .eu_ready_o(rdy[0]), .eu_payload_i(eu_payload),
        .cdb_valid_o(cv[0]), .cdb_ready_i(cdb_ready),
        .cdb_payload_o(cp[0]), .cdb_src_o(cs[0])
    );

    cdb_arbiter #(.EU_N(8), .PAYLOAD_W(72), .RR_EN(1'b0)) u_fp (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .eu_valid_i(eu_valid), .eu_ready_o(rdy[1]), .eu_payload_i(eu_payload),
        .cdb_valid_o(cv[1]), .cdb_ready_i(cdb_ready),
        .cdb_payload_o(cp[1]), .cdb_src_o(cs[1])
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_winner(input logic [7:0] v, input int start);
        for (int k = 0; k < 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    // Inputs only change just after a rising edge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                mv[d] = 1'b0; mp[d] = '0; ms[d] = 0; mptr[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int         w;
                logic       can;
                logic [7:0] er;
                can = !flush && (!mv[d] || cdb_ready);
                w   = find_winner(eu_valid, (d == 0) ? mptr[d] : 0);
                er  = (can && w >= 0) ? 8'(1 << w) : 8'h00;
                chk(d == 0 ? "rr_eu_ready" : "fp_eu_ready", 72'(rdy[d]), 72'(er));
                chk(d == 0 ? "rr_cdb_valid" : "fp_cdb_valid", 72'(cv[d]), 72'(mv[d]));
                if (mv[d]) begin
                    chk(d == 0 ? "rr_cdb_payload" : "fp_cdb_payload", cp[d], mp[d]);
                    chk(d == 0 ? "rr_cdb_src" : "fp_cdb_src", 72'(cs[d]), 72'(ms[d]));
                end
                if (flush) begin
                    mv[d] = 1'b0;
                end else if (can && w >= 0) begin
                    mv[d] = 1'b1;
                    mp[d] = pay[w];
                    ms[d] = w;
                    if (d == 0) mptr[d] = (w + 1) % 8;
                end else if (mv[d] && cdb_ready) begin
                    mv[d] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pay[i] = 72'(i) * 72'h01_0101_0101 + 72'h5A00;

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        #3;
        chk("reset_rr_valid", 72'(cv[0]), 72'h0);
        chk("reset_rr_src", 72'(cs[0]), 72'h0);
        chk("reset_rr_payload", cp[0], 72'h0);
        chk("reset_fp_valid", 72'(cv[1]), 72'h0);
        chk("reset_rr_ready", 72'(rdy[0]), 72'h0);

        // round-robin rotation with all units valid
        tick(); eu_valid = 8'hFF; cdb_ready = 1'b1;
        #3;
        chk("rot_first_ready", 72'(rdy[0]), 72'h01);
        chk("fp_all_ready", 72'(rdy[1]), 72'h01);
        for (int k = 0; k < 9; k++) begin
            tick(); #3;
            chk("rot_valid", 72'(cv[0]), 72'h1);
            chk("rot_src", 72'(cs[0]), 72'(k % 8));
        end
        tick(); eu_valid = 8'h00;

        // pointer skip and wrap (pointer is 2 here)
        tick(); eu_valid = 8'h40; #3;
        chk("skip_ready6", 72'(rdy[0]), 72'h40);
        tick(); eu_valid = 8'h84; #3;
        chk("wrap_ready7", 72'(rdy[0]), 72'h80);
        tick(); eu_valid = 8'h04; #3;
        chk("wrap_ready2", 72'(rdy[0]), 72'h04);
        chk("wrap_src7", 72'(cs[0]), 72'h7);
        tick(); eu_valid = 8'h00; #3;
        chk("wrap_src2", 72'(cs[0]), 72'h2);

        // back-pressure
        tick(); eu_valid = 8'h10; pay[4] = 72'hA5; #3;
        chk("bp_ready4", 72'(rdy[0]), 72'h10);
        tick(); eu_valid = 8'h02; cdb_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) tick();
            #3;
            chk("bp_hold_payload", cp[0], 72'hA5);
            chk("bp_hold_ready", 72'(rdy[0]), 72'h0);
            chk("bp_fp_ready", 72'(rdy[1]), 72'h0);
        end
        tick(); cdb_ready = 1'b1; #3;
        chk("bp_release_ready", 72'(rdy[0]), 72'h02);

        // flush with unit 2 waiting
        tick(); eu_valid = 8'h04; flush = 1'b1; #3;
        chk("bp_src1", 72'(cs[0]), 72'h1);
        chk("flush_ready", 72'(rdy[0]), 72'h0);
        tick(); flush = 1'b0; #3;
        chk("flush_valid", 72'(cv[0]), 72'h0);
        chk("post_flush_ready", 72'(rdy[0]), 72'h04);
        tick(); eu_valid = 8'h0A; #3;
        chk("post_flush_src", 72'(cs[0]), 72'h2);
        chk("ptr_kept_ready", 72'(rdy[0]), 72'h08);

        // fixed priority: unit 1 beats unit 5 repeatedly
        tick(); eu_valid = 8'h22; #3;
        chk("fp_ready1_a", 72'(rdy[1]), 72'h02);
        chk("fp_src1_a", 72'(cs[1]), 72'h1);
        tick(); #3;
        chk("fp_ready1_b", 72'(rdy[1]), 72'h02);
        chk("fp_src1_b", 72'(cs[1]), 72'h1);
        chk("rr_ready1", 72'(rdy[0]), 72'h02);

        // reset asserted during a stall with pointer at 5
        tick(); eu_valid = 8'h10; #3;
        chk("pre_rst_ready4", 72'(rdy[0]), 72'h10);
        tick(); eu_valid = 8'h00; cdb_ready = 1'b0; #1;
        chk("stall_valid", 72'(cv[0]), 72'h1);
        chk("stall_src", 72'(cs[0]), 72'h4);
        rst = 1'b1; #1;
        chk("async_rst_valid", 72'(cv[0]), 72'h0);
        chk("async_rst_src", 72'(cs[0]), 72'h0);
        chk("async_rst_fp_valid", 72'(cv[1]), 72'h0);
        tick(); rst = 1'b0; eu_valid = 8'h09; cdb_ready = 1'b1; #3;
        chk("post_rst_ready0", 72'(rdy[0]), 72'h01);
        tick(); eu_valid = 8'h00; #3;
        chk("post_rst_src", 72'(cs[0]), 72'h0);
        chk("post_rst_valid", 72'(cv[0]), 72'h1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
